// File: rtl/ahb_key_event_ctrl_if.sv
// AHB-Lite bus bundle between a bus master and the key event controller.
// A transfer's address phase is accepted on any HCLK edge with HREADY=1; its data phase ends on the next edge with HREADY=1.
interface ahb_key_event_ctrl_if;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic        HREADY;
   logic        HSEL;
   logic        HREADYOUT;
   logic [31:0] HRDATA;

   modport master (
      output HADDR, HWDATA, HWRITE, HTRANS, HREADY, HSEL,
      input  HREADYOUT, HRDATA
   );

   modport slave (
      input  HADDR, HWDATA, HWRITE, HTRANS, HREADY, HSEL,
      output HREADYOUT, HRDATA
   );
endinterface

// File: rtl/ahb_key_event_ctrl.sv
// Push-button scanner: synchronise, debounce, detect presses and queue them
// as key events readable over AHB-Lite, with a level interrupt while events are pending.
module ahb_key_event_ctrl #(
   parameter int NKEYS           = 5,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   ahb_key_event_ctrl_if.slave  bus,
   input  logic [NKEYS-1:0]     KEY,
   output logic                 KEY_IRQ,
   output logic                 o_dbg_state
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_PRESSED = 1'b1} state_t;

   logic [NKEYS-1:0] r_sync1;
   logic [NKEYS-1:0] r_ks;
   logic [NKEYS-1:0] r_cand;
   logic [NKEYS-1:0] r_stable;
   logic [15:0]      r_db_cnt;
   state_t           r_state;
   logic [NKEYS-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_irq_en;
   logic             r_irq;
   logic             r_sel;
   logic             r_wr;
   logic [1:0]       r_addr;

   logic             w_rd_phase;
   logic             w_wr_phase;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_push_ok;
   logic             w_drop;
   logic             w_ctrl_wr;
   logic [31:0]      w_rdata;
   logic             w_unused_bits;

   assign w_rd_phase = r_sel & ~r_wr & bus.HREADY;
   assign w_wr_phase = r_sel &  r_wr & bus.HREADY;
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_ctrl_wr  = w_wr_phase && (r_addr == 2'd2);

   // The press is queued on the very edge the FSM leaves IDLE.
   assign w_push    = (r_state == ST_IDLE) && (r_stable != '0);
   assign w_pop     = w_rd_phase && (r_addr == 2'd0) && !w_empty;
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;

   assign w_unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:2], bus.HTRANS[0]};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_sel  <= 1'b0;
         r_wr   <= 1'b0;
         r_addr <= 2'd0;
      end else if (bus.HREADY) begin
         r_sel  <= bus.HSEL & bus.HTRANS[1];
         r_wr   <= bus.HWRITE;
         r_addr <= bus.HADDR[3:2];
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_sync1 <= '0;
         r_ks    <= '0;
      end else begin
         r_sync1 <= KEY;
         r_ks    <= r_sync1;
      end
   end

   // Any change of the synchronised value restarts the stability count.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cand   <= '0;
         r_stable <= '0;
         r_db_cnt <= '0;
      end else if (r_ks != r_cand) begin
         r_cand   <= r_ks;
         r_db_cnt <= '0;
      end else if (r_ks != r_stable) begin
         if (r_db_cnt == DB_LIMIT) begin
            r_stable <= r_cand;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (r_stable != '0) r_state <= ST_PRESSED;
            ST_PRESSED: if (r_stable == '0) r_state <= ST_IDLE;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_dbg_state = r_state;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_stable;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
      end
   end

   // A dropped event wins over a same-cycle clear so the loss is never hidden.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_ovf    <= 1'b0;
         r_irq_en <= 1'b1;
         r_irq    <= 1'b0;
      end else begin
         if (w_drop)                            r_ovf <= 1'b1;
         else if (w_ctrl_wr && bus.HWDATA[1])   r_ovf <= 1'b0;
         if (w_ctrl_wr) r_irq_en <= bus.HWDATA[0];
         r_irq <= r_irq_en & !w_empty;
      end
   end

   assign KEY_IRQ = r_irq;

   always_comb begin
      w_rdata = '0;
      if (r_sel && !r_wr) begin
         case (r_addr)
            2'd0: begin
               if (!w_empty) w_rdata[NKEYS-1:0] = r_mem[r_rd_ptr];
               w_rdata[8] = !w_empty;
            end
            2'd1: begin
               w_rdata[CW-1:0] = r_count;
               w_rdata[8]      = w_full;
               w_rdata[9]      = r_ovf;
            end
            2'd2:    w_rdata[0] = r_irq_en;
            default: w_rdata = '0;
         endcase
      end
   end

   assign bus.HRDATA    = w_rdata;
   assign bus.HREADYOUT = 1'b1;

endmodule

// File: tb/tb_ahb_key_event_ctrl.sv
// Self-checking bench for ahb_key_event_ctrl: register table, directed press
// sequences and randomized key activity against a run-length press model.
module tb_ahb_key_event_ctrl;

   localparam int NK    = 5;
   localparam int DB    = 16;
   localparam int DEPTH = 4;
   localparam int LHOLD = DB + 6;

   logic          clk;
   logic          rst_n;
   logic [NK-1:0] key;
   logic          irq;
   logic          dbg_state;

   ahb_key_event_ctrl_if bus ();

   ahb_key_event_ctrl #(
      .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .HCLK(clk), .HRESETn(rst_n), .bus(bus),
      .KEY(key), .KEY_IRQ(irq), .o_dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[11];

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      bus.HADDR  = 32'h0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HWRITE = 1'b0;
      bus.HADDR  = {28'h0, a, 2'b00};
      @(negedge clk);
      bus_idle();
      d = bus.HRDATA;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
      @(negedge clk);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HWRITE = 1'b1;
      bus.HADDR  = {28'h0, a, 2'b00};
      @(negedge clk);
      bus_idle();
      bus.HWDATA = data;
   endtask

   task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      chk(name, d, exp);
      chk("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
   endtask

   task automatic hold_key(input logic [NK-1:0] v, input int n);
      key = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [NK-1:0] v);
      hold_key(v, LHOLD);
      hold_key('0, LHOLD);
   endtask

   initial begin
      logic [31:0]   d;
      logic [NK-1:0] settled, prev, v;
      logic          m_ovf;
      int            nseg, len, n;
      bit            is_long;

      vt[0]  = '{1'b0, 2'd0, 32'h0,        32'h000};
      vt[1]  = '{1'b0, 2'd1, 32'h0,        32'h000};
      vt[2]  = '{1'b0, 2'd2, 32'h0,        32'h001};
      vt[3]  = '{1'b0, 2'd3, 32'h0,        32'h000};
      vt[4]  = '{1'b1, 2'd2, 32'h0,        32'h000};
      vt[5]  = '{1'b0, 2'd2, 32'h0,        32'h000};
      vt[6]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h000};
      vt[7]  = '{1'b0, 2'd3, 32'h0,        32'h000};
      vt[8]  = '{1'b1, 2'd2, 32'h3,        32'h000};
      vt[9]  = '{1'b0, 2'd2, 32'h0,        32'h001};
      vt[10] = '{1'b0, 2'd1, 32'h0,        32'h000};

      rst_n      = 1'b0;
      key        = '0;
      bus.HREADY = 1'b1;
      bus.HWDATA = 32'h0;
      bus_idle();
      repeat (3) @(negedge clk);
      chk("reset_irq", {31'h0, irq}, 32'h0);
      chk("reset_hrdata", bus.HRDATA, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);

      // register table
      for (int i = 0; i < 11; i++) begin
         if (vt[i].wr) bus_write(vt[i].addr, vt[i].wdata);
         else          read_chk($sformatf("table%0d", i), vt[i].addr, vt[i].exp);
      end
      chk("reset_irq_after_table", {31'h0, irq}, 32'h0);

      // press latency: STATUS read every cycle while KEY=00100 settles
      @(negedge clk);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HWRITE = 1'b0;
      bus.HADDR  = 32'h4;
      key        = 5'b00100;
      for (int k = 0; k <= 22; k++) begin
         @(negedge clk);
         chk($sformatf("lat_count_e%0d", k), {27'h0, bus.HRDATA[4:0]}, (k >= DB + 3) ? 32'h1 : 32'h0);
         chk($sformatf("lat_irq_e%0d", k), {31'h0, irq}, (k >= DB + 4) ? 32'h1 : 32'h0);
      end
      bus_idle();
      hold_key('0, LHOLD);
      read_chk("lat_event", 2'd0, 32'h104);
      @(negedge clk);
      chk("irq_after_pop_edge", {31'h0, irq}, 32'h1);
      @(negedge clk);
      chk("irq_next_edge", {31'h0, irq}, 32'h0);
      read_chk("lat_event_empty", 2'd0, 32'h000);

      // glitches shorter than the debounce window, then an 18-cycle hold
      for (int i = 0; i < 4; i++) begin
         hold_key(5'b00001, 10);
         hold_key('0, 10);
      end
      read_chk("glitch_status", 2'd1, 32'h000);
      hold_key(5'b00001, 18);
      hold_key('0, LHOLD);
      read_chk("hold18_status", 2'd1, 32'h001);
      read_chk("hold18_event", 2'd0, 32'h101);
      read_chk("hold18_empty", 2'd0, 32'h000);

      // nonzero-to-nonzero change gives no extra event
      hold_key(5'b00010, LHOLD);
      hold_key(5'b00110, LHOLD);
      hold_key('0, LHOLD);
      press(5'b01000);
      read_chk("chg_status", 2'd1, 32'h002);
      read_chk("chg_ev0", 2'd0, 32'h102);
      read_chk("chg_ev1", 2'd0, 32'h108);
      read_chk("chg_empty", 2'd0, 32'h000);

      // overflow
      for (int i = 0; i < 5; i++) press(NK'(1 << i));
      read_chk("ovf_status", 2'd1, 32'h304);
      chk("ovf_irq", {31'h0, irq}, 32'h1);
      for (int i = 0; i < 4; i++) read_chk($sformatf("ovf_ev%0d", i), 2'd0, 32'h100 | (32'h1 << i));
      read_chk("ovf_status_drained", 2'd1, 32'h200);
      bus_write(2'd2, 32'h3);
      read_chk("ovf_cleared", 2'd1, 32'h000);
      read_chk("ovf_ctrl", 2'd2, 32'h001);

      // pop and push on the same edge while full
      for (int i = 0; i < 4; i++) press(NK'(1 << i));
      read_chk("pp_status_full", 2'd1, 32'h104);
      @(negedge clk);
      key = 5'b10000;
      repeat (DB + 2) @(negedge clk);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HWRITE = 1'b0;
      bus.HADDR  = 32'h0;
      @(negedge clk);
      bus_idle();
      chk("pp_pop_data", bus.HRDATA, 32'h101);
      hold_key(5'b10000, DB);
      hold_key('0, LHOLD);
      read_chk("pp_status", 2'd1, 32'h104);
      chk("pp_irq", {31'h0, irq}, 32'h1);
      bus_write(2'd2, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("irq_en_off", {31'h0, irq}, 32'h0);
      read_chk("irq_en_off_status", 2'd1, 32'h104);
      bus_write(2'd2, 32'h1);
      read_chk("pp_ev0", 2'd0, 32'h102);
      read_chk("pp_ev1", 2'd0, 32'h104);
      read_chk("pp_ev2", 2'd0, 32'h108);
      read_chk("pp_ev3", 2'd0, 32'h110);
      read_chk("pp_empty", 2'd0, 32'h000);

      // randomized key activity vs run-length model
      settled = '0;
      prev    = '0;
      m_ovf   = 1'b0;
      exp_q.delete();
      for (int r = 0; r < 6; r++) begin
         nseg = $urandom_range(4, 7);
         for (int s = 0; s < nseg; s++) begin
            v = NK'($urandom_range(0, (1 << NK) - 1));
            if (v == prev) v = v ^ NK'(1);
            is_long = (s == nseg - 1) || ($urandom_range(0, 1) == 1);
            len = is_long ? $urandom_range(DB + 6, DB + 20) : $urandom_range(1, DB - 4);
            hold_key(v, len);
            if (is_long) begin
               if (settled == '0 && v != '0) begin
                  if (exp_q.size() < DEPTH) exp_q.push_back(32'h100 | 32'(v));
                  else m_ovf = 1'b1;
               end
               settled = v;
            end
            prev = v;
         end
         read_chk($sformatf("rnd%0d_status", r), 2'd1,
                  {22'h0, m_ovf, (exp_q.size() == DEPTH), 3'h0, 5'(exp_q.size())});
         chk($sformatf("rnd%0d_irq", r), {31'h0, irq}, {31'h0, (exp_q.size() != 0)});
         n = exp_q.size();
         for (int i = 0; i < n; i++) begin
            bus_read(2'd0, d);
            chk($sformatf("rnd%0d_ev%0d", r, i), d, exp_q.pop_front());
         end
         read_chk($sformatf("rnd%0d_empty", r), 2'd0, 32'h000);
         bus_write(2'd2, 32'h3);
         m_ovf = 1'b0;
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
